ctrl_tx_scheduler: RTL and testbench



---
 rtl/ctrl_tx_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_ctrl_tx_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_tx_scheduler.sv
// ----------------------------------------------------------------------------
// ctrl_tx_scheduler
//
// Transmit-side scheduler for the system controller. It buffers one request
// from the register-file path (one byte) and one from the ALU path (two bytes).
// It then serialises them onto the single UART transmitter using a
// valid/busy handshake.
//
// Ports:
//   clk              system clock, all logic on the rising edge
//   rst              asynchronous, active-low reset
//   RF_SEND_TX       register-file read data (DATA_WIDTH)
//   RF_SEND_TX_FLAG  register-file send request
//   ALU_OUT_LATCHED  latched ALU result (ALU_WIDTH)
//   ALU_SEND_FLAG    ALU send request, may be held high for several cycles
//   TX_BUSY          UART transmitter busy
//   TX_P_DATA        registered byte presented to the UART transmitter
//   TX_D_VLD         registered one-cycle byte-valid strobe
//   TX_ACTIVE        high whenever the scheduler is not idle
//   OVERFLOW_ERR     sticky flag: a request arrived for a full slot
// ----------------------------------------------------------------------------
module ctrl_tx_scheduler #(
    parameter int DATA_WIDTH  = 8,
    parameter int ALU_WIDTH   = 16,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] RF_SEND_TX,
    input  logic                  RF_SEND_TX_FLAG,
    input  logic [ALU_WIDTH-1:0]  ALU_OUT_LATCHED,
    input  logic                  ALU_SEND_FLAG,
    input  logic                  TX_BUSY,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    output logic                  TX_ACTIVE,
    output logic                  OVERFLOW_ERR
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    state_t                 state;
    state_t                 next_state;

    logic                   rf_flag_q;
    logic                   alu_flag_q;
    logic                   rf_req_q;
    logic                   alu_req_q;

    logic [DATA_WIDTH-1:0]  rf_slot;
    logic [ALU_WIDTH-1:0]   alu_slot;
    logic                   rf_pending;
    logic                   alu_pending;

    logic [ALU_WIDTH-1:0]   hold;
    logic                   high_left;
    logic                   last_alu;
    logic [CNT_W-1:0]       ack_cnt;

    logic                   select;
    logic                   pick_rf;
    logic                   rf_clear;
    logic                   alu_clear;
    logic                   load_high;
    logic                   ack_expired;

    // Selection happens only from IDLE with the transmitter free. The
    // round-robin pointer gives RF the tie unless RF was the last one served.
    always_comb begin
        select      = (state == IDLE) && (rf_pending || alu_pending) && !TX_BUSY;
        pick_rf     = rf_pending && (!alu_pending || last_alu);
        rf_clear    = select && pick_rf;
        alu_clear   = select && !pick_rf;
        load_high   = (state == WAIT_DONE) && !TX_BUSY && high_left;
        ack_expired = (ack_cnt == CNT_W'(ACK_TIMEOUT - 1));
    end

    // Next-state logic. The strobe itself is registered from next_state.
    // This keeps TX_D_VLD glitch-free and gives it exactly one cycle in SEND.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:      if (select) next_state = SEND;
            SEND:      next_state = WAIT_ACK;
            WAIT_ACK: begin
                if (TX_BUSY)          next_state = WAIT_DONE;
                else if (ack_expired) next_state = SEND;
            end
            WAIT_DONE: begin
                if (!TX_BUSY) next_state = high_left ? SEND : IDLE;
            end
            default:   next_state = IDLE;
        endcase
    end

    assign TX_ACTIVE = (state != IDLE);

    // State register, valid strobe and ack-wait counter.
    // The counter restarts in every SEND, so each retry gets a full timeout window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            TX_D_VLD <= 1'b0;
            ack_cnt  <= '0;
        end else begin
            state    <= next_state;
            TX_D_VLD <= (next_state == SEND);
            if (state == SEND)
                ack_cnt <= '0;
            else if (state == WAIT_ACK)
                ack_cnt <= ack_cnt + CNT_W'(1);
        end
    end

    // Request edge detection. The detect is registered, so data is captured
    // one edge after the flag cycle, once the source registers have settled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_flag_q  <= 1'b0;
            alu_flag_q <= 1'b0;
            rf_req_q   <= 1'b0;
            alu_req_q  <= 1'b0;
        end else begin
            rf_flag_q  <= RF_SEND_TX_FLAG;
            alu_flag_q <= ALU_SEND_FLAG;
            rf_req_q   <= RF_SEND_TX_FLAG && !rf_flag_q;
            alu_req_q  <= ALU_SEND_FLAG && !alu_flag_q;
        end
    end

    // Per-source slots. A request into a slot that is still pending is
    // dropped and flagged. If the slot is emptied by selection on the same
    // edge, the request refills it instead.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_slot      <= '0;
            alu_slot     <= '0;
            rf_pending   <= 1'b0;
            alu_pending  <= 1'b0;
            OVERFLOW_ERR <= 1'b0;
        end else begin
            if (rf_req_q) begin
                if (rf_pending && !rf_clear) begin
                    OVERFLOW_ERR <= 1'b1;
                end else begin
                    rf_slot    <= RF_SEND_TX;
                    rf_pending <= 1'b1;
                end
            end else if (rf_clear) begin
                rf_pending <= 1'b0;
            end

            if (alu_req_q) begin
                if (alu_pending && !alu_clear) begin
                    OVERFLOW_ERR <= 1'b1;
                end else begin
                    alu_slot    <= ALU_OUT_LATCHED;
                    alu_pending <= 1'b1;
                end
            end else if (alu_clear) begin
                alu_pending <= 1'b0;
            end
        end
    end

    // Holding register and output byte. The ALU low byte goes first. The
    // high byte is loaded when the transmitter frees up after the low byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold      <= '0;
            high_left <= 1'b0;
            last_alu  <= 1'b1;
            TX_P_DATA <= '0;
        end else if (select) begin
            if (pick_rf) begin
                hold      <= {{(ALU_WIDTH - DATA_WIDTH){1'b0}}, rf_slot};
                TX_P_DATA <= rf_slot;
                high_left <= 1'b0;
                last_alu  <= 1'b0;
            end else begin
                hold      <= alu_slot;
                TX_P_DATA <= alu_slot[DATA_WIDTH-1:0];
                high_left <= 1'b1;
                last_alu  <= 1'b1;
            end
        end else if (load_high) begin
            TX_P_DATA <= hold[ALU_WIDTH-1:DATA_WIDTH];
            high_left <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ctrl_tx_scheduler.sv
// ----------------------------------------------------------------------------
// tb_ctrl_tx_scheduler
//
// Directed testbench for ctrl_tx_scheduler. The DUT runs with ACK_TIMEOUT=4.
// A monitor records every valid strobe (byte and cycle). An optional UART
// model raises TX_BUSY one cycle after a strobe and holds it for 20 cycles.
// Inputs change on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_ctrl_tx_scheduler;

    logic        clk;
    logic        rst;
    logic [7:0]  RF_SEND_TX;
    logic        RF_SEND_TX_FLAG;
    logic [15:0] ALU_OUT_LATCHED;
    logic        ALU_SEND_FLAG;
    logic        TX_BUSY;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        TX_ACTIVE;
    logic        OVERFLOW_ERR;

    int          checks;
    int          fails;
    int          cyc;
    int          flag_cyc;

    logic [7:0]  sq[$];
    int          scyc[$];
    int          fq[$];

    bit          auto_busy;
    bit          arm;
    int          busy_cnt;

    localparam int BUSY_LEN = 20;

    ctrl_tx_scheduler #(
        .DATA_WIDTH  (8),
        .ALU_WIDTH   (16),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .RF_SEND_TX      (RF_SEND_TX),
        .RF_SEND_TX_FLAG (RF_SEND_TX_FLAG),
        .ALU_OUT_LATCHED (ALU_OUT_LATCHED),
        .ALU_SEND_FLAG   (ALU_SEND_FLAG),
        .TX_BUSY         (TX_BUSY),
        .TX_P_DATA       (TX_P_DATA),
        .TX_D_VLD        (TX_D_VLD),
        .TX_ACTIVE       (TX_ACTIVE),
        .OVERFLOW_ERR    (OVERFLOW_ERR)
    );

    // Free-running clock plus a cycle counter used for latency checks.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor plus the automatic UART busy model.
    // Both act on the falling edge, so they see stable DUT outputs.
    initial begin
        arm      = 1'b0;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (auto_busy) begin
                if (busy_cnt > 0) begin
                    busy_cnt = busy_cnt - 1;
                    if (busy_cnt == 0) begin
                        TX_BUSY = 1'b0;
                        fq.push_back(cyc);
                    end
                end else if (arm) begin
                    TX_BUSY  = 1'b1;
                    busy_cnt = BUSY_LEN;
                    arm      = 1'b0;
                end
            end
            if (rst === 1'b1 && TX_D_VLD === 1'b1) begin
                sq.push_back(TX_P_DATA);
                scyc.push_back(cyc);
                if (auto_busy) arm = 1'b1;
            end
        end
    end

    // Global watchdog: the run must never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_strobes(input int n, input int budget);
        int k;
        k = 0;
        while (sq.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (sq.size() < n) begin
            checks++;
            fails++;
            $display("[TB] FAIL strobe_wait: got %0d strobes, required %0d", sq.size(), n);
        end
    endtask

    task automatic pulse_flags(input bit rf, input bit alu, input logic [7:0] rd,
                               input logic [15:0] ad);
        @(negedge clk);
        RF_SEND_TX      = rd;
        ALU_OUT_LATCHED = ad;
        RF_SEND_TX_FLAG = rf;
        ALU_SEND_FLAG   = alu;
        flag_cyc        = cyc;
        @(negedge clk);
        RF_SEND_TX_FLAG = 1'b0;
        ALU_SEND_FLAG   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sq.delete();
        scyc.delete();
        fq.delete();
        arm      = 1'b0;
        busy_cnt = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 4;
        if (TX_P_DATA !== 8'h00) begin fails++; $display("[TB] FAIL reset_data: got %h, required 00", TX_P_DATA); end
        if (TX_D_VLD !== 1'b0) begin fails++; $display("[TB] FAIL reset_vld: got %b, required 0", TX_D_VLD); end
        if (TX_ACTIVE !== 1'b0) begin fails++; $display("[TB] FAIL reset_active: got %b, required 0", TX_ACTIVE); end
        if (OVERFLOW_ERR !== 1'b0) begin fails++; $display("[TB] FAIL reset_ovf: got %b, required 0", OVERFLOW_ERR); end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (TX_ACTIVE !== 1'b0 || sq.size() != 0) begin
            fails++;
            $display("[TB] FAIL idle_after_reset: active %b strobes %0d, required 0 and 0", TX_ACTIVE, sq.size());
        end
    endtask

    task automatic test_rf_single();
        auto_busy = 1'b1;
        pulse_flags(1'b1, 1'b0, 8'h5A, 16'h0000);
        wait_strobes(1, 20);
        repeat (5) @(negedge clk);
        checks += 2;
        if (TX_ACTIVE !== 1'b1) begin fails++; $display("[TB] FAIL rf_active_busy: got %b, required 1", TX_ACTIVE); end
        if (TX_P_DATA !== 8'h5A) begin fails++; $display("[TB] FAIL rf_data_stable: got %h, required 5a", TX_P_DATA); end
        repeat (25) @(negedge clk);
        checks += 4;
        if (sq.size() != 1) begin fails++; $display("[TB] FAIL rf_strobe_count: got %0d, required 1", sq.size()); end
        if (sq.size() >= 1) begin
            if (sq[0] !== 8'h5A) begin fails++; $display("[TB] FAIL rf_byte: got %h, required 5a", sq[0]); end
            if (scyc[0] != flag_cyc + 3) begin fails++; $display("[TB] FAIL rf_latency: got cycle %0d, required %0d", scyc[0], flag_cyc + 3); end
        end else begin
            fails += 2;
            $display("[TB] FAIL rf_byte: got no strobe, required 5a");
        end
        if (TX_ACTIVE !== 1'b0) begin fails++; $display("[TB] FAIL rf_active_done: got %b, required 0", TX_ACTIVE); end
        checks++;
        if (TX_P_DATA !== 8'h5A) begin fails++; $display("[TB] FAIL rf_data_retained: got %h, required 5a", TX_P_DATA); end
    endtask

    task automatic test_alu_pair();
        int n;
        sq.delete(); scyc.delete(); fq.delete();
        @(negedge clk);
        ALU_OUT_LATCHED = 16'hBEEF;
        ALU_SEND_FLAG   = 1'b1;
        n = cyc;
        repeat (3) @(negedge clk);
        ALU_SEND_FLAG = 1'b0;
        wait_strobes(2, 80);
        repeat (30) @(negedge clk);
        checks += 2;
        if (sq.size() != 2) begin fails++; $display("[TB] FAIL alu_strobe_count: got %0d, required 2", sq.size()); end
        if (OVERFLOW_ERR !== 1'b0) begin fails++; $display("[TB] FAIL alu_no_ovf: got %b, required 0", OVERFLOW_ERR); end
        if (sq.size() >= 2 && fq.size() >= 1) begin
            checks += 4;
            if (sq[0] !== 8'hEF) begin fails++; $display("[TB] FAIL alu_low: got %h, required ef", sq[0]); end
            if (sq[1] !== 8'hBE) begin fails++; $display("[TB] FAIL alu_high: got %h, required be", sq[1]); end
            if (scyc[0] != n + 3) begin fails++; $display("[TB] FAIL alu_latency: got %0d, required %0d", scyc[0], n + 3); end
            if (scyc[1] != fq[0] + 1) begin fails++; $display("[TB] FAIL alu_byte_gap: got %0d, required %0d", scyc[1], fq[0] + 1); end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp[$];
        do_reset();
        auto_busy = 1'b1;
        exp = '{8'hA1, 8'h34, 8'h12, 8'hB2, 8'h78, 8'h56, 8'hC3, 8'hBC, 8'h9A, 8'hD4};
        pulse_flags(1'b1, 1'b1, 8'hA1, 16'h1234);
        wait_strobes(3, 150);
        repeat (30) @(negedge clk);
        pulse_flags(1'b1, 1'b1, 8'hB2, 16'h5678);
        wait_strobes(6, 150);
        repeat (30) @(negedge clk);
        pulse_flags(1'b1, 1'b0, 8'hC3, 16'h0000);
        wait_strobes(7, 60);
        repeat (30) @(negedge clk);
        pulse_flags(1'b1, 1'b1, 8'hD4, 16'h9ABC);
        wait_strobes(10, 150);
        repeat (30) @(negedge clk);
        checks++;
        if (sq.size() != exp.size()) begin
            fails++;
            $display("[TB] FAIL rr_count: got %0d, required %0d", sq.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < sq.size(); i++) begin
            checks++;
            if (sq[i] !== exp[i]) begin
                fails++;
                $display("[TB] FAIL rr_byte%0d: got %h, required %h", i, sq[i], exp[i]);
            end
        end
        if (scyc.size() >= 2 && fq.size() >= 1) begin
            checks++;
            if (scyc[1] != fq[0] + 2) begin
                fails++;
                $display("[TB] FAIL rr_source_gap: got %0d, required %0d", scyc[1], fq[0] + 2);
            end
        end
    endtask

    task automatic test_timeout_retry();
        sq.delete(); scyc.delete();
        auto_busy = 1'b0;
        @(negedge clk);
        TX_BUSY = 1'b0;
        pulse_flags(1'b1, 1'b0, 8'h3C, 16'h0000);
        wait_strobes(3, 40);
        if (scyc.size() >= 3) begin
            while (cyc < scyc[2] + 1) @(negedge clk);
        end
        TX_BUSY = 1'b1;
        repeat (12) @(negedge clk);
        checks += 2;
        if (sq.size() != 3) begin fails++; $display("[TB] FAIL retry_count: got %0d, required 3", sq.size()); end
        if (TX_ACTIVE !== 1'b1) begin fails++; $display("[TB] FAIL retry_active_busy: got %b, required 1", TX_ACTIVE); end
        if (sq.size() >= 3) begin
            checks += 3;
            if (sq[0] !== 8'h3C || sq[1] !== 8'h3C || sq[2] !== 8'h3C) begin
                fails++;
                $display("[TB] FAIL retry_bytes: got %h %h %h, required 3c 3c 3c", sq[0], sq[1], sq[2]);
            end
            if (scyc[1] - scyc[0] != 5) begin fails++; $display("[TB] FAIL retry_gap1: got %0d, required 5", scyc[1] - scyc[0]); end
            if (scyc[2] - scyc[1] != 5) begin fails++; $display("[TB] FAIL retry_gap2: got %0d, required 5", scyc[2] - scyc[1]); end
        end
        TX_BUSY = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (TX_ACTIVE !== 1'b0 || sq.size() != 3) begin
            fails++;
            $display("[TB] FAIL retry_done: active %b strobes %0d, required 0 and 3", TX_ACTIVE, sq.size());
        end
    endtask

    task automatic test_overflow_reset();
        sq.delete(); scyc.delete();
        auto_busy = 1'b0;
        @(negedge clk);
        TX_BUSY = 1'b1;
        pulse_flags(1'b1, 1'b0, 8'h11, 16'h0000);
        repeat (4) @(negedge clk);
        checks++;
        if (OVERFLOW_ERR !== 1'b0) begin fails++; $display("[TB] FAIL ovf_first: got %b, required 0", OVERFLOW_ERR); end
        pulse_flags(1'b1, 1'b0, 8'h22, 16'h0000);
        repeat (4) @(negedge clk);
        pulse_flags(1'b1, 1'b0, 8'h33, 16'h0000);
        repeat (5) @(negedge clk);
        checks += 3;
        if (sq.size() != 0) begin fails++; $display("[TB] FAIL stall_no_issue: got %0d strobes, required 0", sq.size()); end
        if (OVERFLOW_ERR !== 1'b1) begin fails++; $display("[TB] FAIL ovf_set: got %b, required 1", OVERFLOW_ERR); end
        if (TX_ACTIVE !== 1'b0) begin fails++; $display("[TB] FAIL stall_idle: got %b, required 0", TX_ACTIVE); end
        TX_BUSY = 1'b0;
        wait_strobes(1, 10);
        TX_BUSY = 1'b1;
        repeat (3) @(negedge clk);
        checks += 3;
        if (sq.size() >= 1) begin
            if (sq[0] !== 8'h11) begin fails++; $display("[TB] FAIL ovf_kept_old: got %h, required 11", sq[0]); end
        end else begin
            fails++;
            $display("[TB] FAIL ovf_kept_old: got no strobe, required 11");
        end
        if (TX_ACTIVE !== 1'b1) begin fails++; $display("[TB] FAIL wait_done_active: got %b, required 1", TX_ACTIVE); end
        if (OVERFLOW_ERR !== 1'b1) begin fails++; $display("[TB] FAIL ovf_sticky: got %b, required 1", OVERFLOW_ERR); end
        rst = 1'b0;
        #1;
        checks += 4;
        if (TX_P_DATA !== 8'h00) begin fails++; $display("[TB] FAIL midreset_data: got %h, required 00", TX_P_DATA); end
        if (TX_D_VLD !== 1'b0) begin fails++; $display("[TB] FAIL midreset_vld: got %b, required 0", TX_D_VLD); end
        if (TX_ACTIVE !== 1'b0) begin fails++; $display("[TB] FAIL midreset_active: got %b, required 0", TX_ACTIVE); end
        if (OVERFLOW_ERR !== 1'b0) begin fails++; $display("[TB] FAIL midreset_ovf: got %b, required 0", OVERFLOW_ERR); end
        @(negedge clk);
        TX_BUSY = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (sq.size() != 1 || TX_ACTIVE !== 1'b0) begin
            fails++;
            $display("[TB] FAIL after_reset_idle: strobes %0d active %b, required 1 and 0", sq.size(), TX_ACTIVE);
        end
    endtask

    initial begin
        checks          = 0;
        fails           = 0;
        flag_cyc        = 0;
        auto_busy       = 1'b0;
        rst             = 1'b0;
        RF_SEND_TX      = 8'h00;
        RF_SEND_TX_FLAG = 1'b0;
        ALU_OUT_LATCHED = 16'h0000;
        ALU_SEND_FLAG   = 1'b0;
        TX_BUSY         = 1'b0;

        test_reset();
        test_rf_single();
        test_alu_pair();
        test_round_robin();
        test_timeout_retry();
        test_overflow_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
